// File: rtl/sprite_pkg.sv
// Shared constants and state type for the rotating sprite drawer.
package sprite_pkg;

  localparam int unsigned NUM_FRAMES      = 24;
  localparam int unsigned FRAMES_PER_QUAD = 6;
  localparam int unsigned FRAME_W         = 5;

  // Bit fields of the 6-bit direction vector
  localparam int unsigned DIR_X_SIGN = 5;
  localparam int unsigned DIR_DX_HI  = 4;
  localparam int unsigned DIR_DX_LO  = 3;
  localparam int unsigned DIR_Y_SIGN = 2;
  localparam int unsigned DIR_DY_HI  = 1;
  localparam int unsigned DIR_DY_LO  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/sprite_frame_sel.sv
// Combinational mapping of a direction vector onto one of 24 clockwise rotation frames.
module sprite_frame_sel
  import sprite_pkg::*;
(
  input  logic [5:0]         direction_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               valid_o
);

  localparam logic [FRAME_W-1:0] Half = FRAME_W'(2 * FRAMES_PER_QUAD);
  localparam logic [FRAME_W-1:0] Full = FRAME_W'(NUM_FRAMES);

  logic [1:0]         adx, ady;
  logic               x_left, y_up;
  logic [FRAME_W-1:0] s;

  assign adx     = direction_i[DIR_DX_HI:DIR_DX_LO];
  assign ady     = direction_i[DIR_DY_HI:DIR_DY_LO];
  assign x_left  = direction_i[DIR_X_SIGN];
  assign y_up    = direction_i[DIR_Y_SIGN];
  assign valid_o = (adx != 2'd0) || (ady != 2'd0);

  // s: 0 = pure vertical ... 6 = pure horizontal, within one quadrant
  always_comb begin
    s = '0;
    if (adx == 2'd0) begin
      s = FRAME_W'(0);
    end else if (ady == 2'd0) begin
      s = FRAME_W'(6);
    end else if (adx == ady) begin
      s = FRAME_W'(3);
    end else begin
      case ({adx, ady})
        4'b01_11:          s = FRAME_W'(1);
        4'b01_10, 4'b10_11: s = FRAME_W'(2);
        4'b11_10, 4'b10_01: s = FRAME_W'(4);
        4'b11_01:          s = FRAME_W'(5);
        default:           s = FRAME_W'(3);
      endcase
    end
  end

  always_comb begin
    frame_o = '0;
    unique case ({x_left, y_up})
      2'b01:   frame_o = s;
      2'b00:   frame_o = Half - s;
      2'b10:   frame_o = Half + s;
      default: frame_o = (s == '0) ? '0 : Full - s;
    endcase
  end

endmodule

// File: rtl/draw_rotsprite.sv
// Scans a square sprite frame from an external ROM and streams pixels to the VGA write port.
// Optional SPRITE_ERASE_EN adds an erase input that redraws visible pixels in colour 0.
module draw_rotsprite
  import sprite_pkg::*;
#(
  parameter  int unsigned SPRITE_SIZE = 32,
  parameter  int unsigned COORD_W     = 10,
  parameter  int unsigned COLOR_W     = 3,
  parameter  int unsigned TRANSPARENT = 0,
  localparam int unsigned ROM_ADDR_W  = FRAME_W + 2 * $clog2(SPRITE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  plot,
  input  logic [COORD_W-1:0]    x_pos,
  input  logic [COORD_W-1:0]    y_pos,
  input  logic [5:0]            direction,
  output logic [ROM_ADDR_W-1:0] rom_address,
  input  logic [COLOR_W-1:0]    rom_data,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic [COLOR_W-1:0]    color,
  output logic                  writeEn,
  output logic                  busy,
`ifdef SPRITE_ERASE_EN
  input  logic                  erase,
`endif
  output logic                  done
);

  localparam int unsigned SizeLog = $clog2(SPRITE_SIZE);
  localparam int unsigned PixW    = 2 * SizeLog;
  localparam logic [COLOR_W-1:0] TranspC = COLOR_W'(TRANSPARENT);

  state_e               state_q, state_d;
  logic [PixW-1:0]      cnt_q, cnt_d;
  logic                 flush_q, flush_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 erase_en;
  logic [FRAME_W-1:0]   sel_frame;
  logic                 sel_valid;
  logic [SizeLog-1:0]   col, row;

  sprite_frame_sel u_frame_sel (
    .direction_i (direction),
    .frame_o     (sel_frame),
    .valid_o     (sel_valid)
  );

  assign col = cnt_q[SizeLog-1:0];
  assign row = cnt_q[PixW-1:SizeLog];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    frame_d     = frame_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x_d         = x0_q + COORD_W'(col);
    y_d         = y0_q + COORD_W'(row);
    pix_valid_d = (state_q == StScan);
    unique case (state_q)
      StIdle: begin
        if (plot) begin
          state_d = StScan;
          cnt_d   = '0;
          x0_d    = x_pos;
          y0_d    = y_pos;
          if (sel_valid) frame_d = sel_frame;
        end
      end
      StScan: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end
      end
      StFlush: begin
        flush_d = 1'b1;
        if (flush_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      frame_q     <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      frame_q     <= frame_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
    end
  end

`ifdef SPRITE_ERASE_EN
  logic erase_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      erase_q <= 1'b0;
    end else if (state_q == StIdle && plot) begin
      erase_q <= erase;
    end
  end
  assign erase_en = erase_q;
`else
  assign erase_en = 1'b0;
`endif

  // cnt_q < SIZE^2, so concatenation equals frame*SIZE^2 + row*SIZE + col
  assign rom_address = {frame_q, cnt_q};
  assign x           = x_q;
  assign y           = y_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

  // ROM word arrives in the same cycle as its registered coordinates
  always_comb begin
    writeEn = pix_valid_q && (rom_data != TranspC);
    color   = '0;
    if (pix_valid_q && !(erase_en && writeEn)) color = rom_data;
  end

endmodule

// File: tb/tb_draw_rotsprite.sv
// Randomized self-checking bench for draw_rotsprite against a behavioural sprite model.
module tb_draw_rotsprite;

  localparam int unsigned S    = 32;
  localparam int unsigned NPIX = S * S;
  localparam int unsigned AW   = 5 + 2 * $clog2(S);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          plot = 1'b0;
  logic [9:0]    x_pos = '0;
  logic [9:0]    y_pos = '0;
  logic [5:0]    direction = '0;
  logic [AW-1:0] rom_address;
  logic [2:0]    rom_data;
  logic [9:0]    x, y;
  logic [2:0]    color;
  logic          writeEn, busy, done;
`ifdef SPRITE_ERASE_EN
  logic          erase = 1'b0;
`endif

  logic [2:0] rom_mem [0:(1<<AW)-1];
  int n_total = 0;
  int n_bad   = 0;
  int model_frame = 0;

  draw_rotsprite dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .plot        (plot),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .direction   (direction),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .x           (x),
    .y           (y),
    .color       (color),
    .writeEn     (writeEn),
    .busy        (busy),
`ifdef SPRITE_ERASE_EN
    .erase       (erase),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_address];

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame from compass geometry: slope class within a quadrant, then clockwise from up
  function automatic int ref_frame(input logic [5:0] dir, input int prev);
    int tbl [4][4];
    int adx, ady, s, f;
    tbl = '{'{0, 0, 0, 0}, '{6, 3, 2, 1}, '{6, 4, 3, 2}, '{6, 5, 4, 3}};
    adx = int'(dir[4:3]);
    ady = int'(dir[1:0]);
    if (adx == 0 && ady == 0) return prev;
    s = tbl[adx][ady];
    if (!dir[5] && dir[2])       f = s;
    else if (!dir[5] && !dir[2]) f = 12 - s;
    else if (dir[5] && !dir[2])  f = 12 + s;
    else                         f = 24 - s;
    return f % 24;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 3'($urandom);
  endtask

  task automatic fill_third();
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = (i % 3 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
  endtask

  task automatic draw(input string tag, input logic [9:0] x0, input logic [9:0] y0,
                      input logic [5:0] dir, input int mid_plot, input bit hold,
                      input bit erase_v);
    int base, exp_we, n_we, done_at, done_extra;
    int addr_mis, pix_mis, we_mis, col_mis, busy_mis, seen;
    model_frame = ref_frame(dir, model_frame);
    base = model_frame * NPIX;
    exp_we = 0;
    for (int i = 0; i < NPIX; i++) if (rom_mem[base + i] != 3'd0) exp_we++;
    n_we = 0; done_at = -1; done_extra = 0;
    addr_mis = 0; pix_mis = 0; we_mis = 0; col_mis = 0; busy_mis = 0;
    @(negedge clk);
    x_pos = x0; y_pos = y0; direction = dir; plot = 1'b1;
`ifdef SPRITE_ERASE_EN
    erase = erase_v;
`endif
    for (int k = 1; k <= int'(NPIX) + 4; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) plot = 1'b0;
      if (mid_plot != 0 && k == mid_plot) begin
        plot = 1'b1; x_pos = ~x0; direction = 6'b011000;
      end
      if (mid_plot != 0 && k == mid_plot + 1) plot = 1'b0;
      if (k <= int'(NPIX) && rom_address !== AW'(base + k - 1)) addr_mis++;
      if (k >= 2 && k <= int'(NPIX) + 1) begin
        int idx;
        logic [2:0] w;
        idx = k - 2;
        w = rom_mem[base + idx];
        if (writeEn !== (w != 3'd0)) we_mis++;
        if (x !== 10'(int'(x0) + idx % S) || y !== 10'(int'(y0) + idx / S)) pix_mis++;
        if (w != 3'd0 && color !== (erase_v ? 3'd0 : w)) col_mis++;
        if (writeEn === 1'b1) n_we++;
      end else if (writeEn !== 1'b0) begin
        we_mis++;
      end
      if (busy !== (k <= int'(NPIX) + 3)) busy_mis++;
      if (done === 1'b1) begin
        if (done_at < 0) done_at = k;
        else done_extra++;
      end
    end
    check({tag, ".addr"}, addr_mis, 0);
    check({tag, ".xy"}, pix_mis, 0);
    check({tag, ".we"}, we_mis, 0);
    check({tag, ".color"}, col_mis, 0);
    check({tag, ".busy"}, busy_mis, 0);
    check({tag, ".done_cycle"}, done_at, NPIX + 3);
    check({tag, ".done_once"}, done_extra, 0);
    check({tag, ".we_count"}, n_we, exp_we);
    if (hold) begin
      @(negedge clk);
      check({tag, ".retrigger_busy"}, busy, 1);
      plot = 1'b0;
      seen = 0;
      for (int k = 0; k < int'(NPIX) + 10 && seen == 0; k++) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1;
      end
      check({tag, ".retrigger_done"}, seen, 1);
    end
  endtask

  initial begin
    int seen;
    #1;
    check("rst.x", x, 0);
    check("rst.y", y, 0);
    check("rst.color", color, 0);
    check("rst.addr", rom_address, 0);
    check("rst.we", writeEn, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    fill_random();
    draw("up", 10'd100, 10'd50, 6'b000101, 0, 1'b0, 1'b0);
    draw("left", 10'd200, 10'd300, 6'b101000, 0, 1'b0, 1'b0);
    draw("right", 10'd7, 10'd9, 6'b011000, 0, 1'b0, 1'b0);
    draw("f8", 10'd40, 10'd60, 6'b010001, 0, 1'b0, 1'b0);
    fill_third();
    draw("down_third", 10'd300, 10'd100, 6'b000001, 0, 1'b0, 1'b0);
    draw("zero_wrap", 10'd1010, 10'd20, 6'b000000, 0, 1'b0, 1'b0);
    fill_random();
    draw("mid_plot", 10'($urandom), 10'($urandom), 6'($urandom), 300, 1'b0, 1'b0);
    draw("hold", 10'd5, 10'd5, 6'b110110, 0, 1'b1, 1'b0);

    // Abort while pixel 500 is on the output
    @(negedge clk);
    x_pos = 10'd64; y_pos = 10'd32; direction = 6'b001111; plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
    repeat (501) @(negedge clk);
    check("abort.x", x, 64 + 500 % S);
    reset_n = 1'b0;
    #1;
    check("abort.we", writeEn, 0);
    check("abort.busy", busy, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1;
    end
    check("abort.no_done", seen, 0);
    reset_n = 1'b1;
    model_frame = 0;
    draw("after_rst", 10'd1, 10'd2, 6'b000000, 0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++)
      draw("rand", 10'($urandom), 10'($urandom), 6'($urandom), 0, 1'b0, 1'b0);
`ifdef SPRITE_ERASE_EN
    draw("erase", 10'd500, 10'd400, 6'b111011, 0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
